// File: rtl/lut_m_frac.sv
// Fracturable memory LUT: beat-wise configuration loader, ROM/RAM/SRL run-time
// modes, optional dual (INPUTS-1)-input read and an SRL cascade output.
module lut_m_frac #(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUTS-1:0]       addr,
    input  logic                    frac,
    input  logic [1:0]              mode,
    input  logic                    cen,
    input  logic [CONFIG_WIDTH-1:0] config_in,
    output logic                    config_done,
    input  logic                    data_in,
    input  logic                    write_en,
    input  logic [INPUTS-1:0]       waddr,
    output logic [1:0]              out,
    output logic                    shift_out
);

    localparam int BEATS = MEM_SIZE / CONFIG_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = (BEATS > 1) ? CNT_W'(1) : CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    localparam logic [1:0] MODE_RAM = 2'b01;
    localparam logic [1:0] MODE_SRL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    w_beat_sel;
    logic [MEM_SIZE-1:0] r_mem;
    logic [MEM_SIZE-1:0] w_mem_next;
    logic                w_user_wr;
    logic                w_config_done;
    logic [INPUTS-1:0]   w_lo_addr;
    logic [INPUTS-1:0]   w_hi_addr;
    logic [1:0]          w_out;

    // Loader state, beat counter and LUT storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_mem   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mem   <= w_mem_next;
        end
    end

    // Loader next-state: any cen outside LOAD (re)starts at beat 0
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cen) begin
                    w_state_next = (BEATS == 1) ? ST_DONE : ST_LOAD;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_state_next = r_state;
                    w_cnt_next   = r_cnt;
                end
            end
            ST_LOAD: begin
                if (cen) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_DONE;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_state_next = ST_LOAD;
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_next = ST_LOAD;
                    w_cnt_next   = r_cnt;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    assign w_beat_sel = (r_state == ST_LOAD) ? r_cnt : CNT_ZERO;
    assign w_user_wr  = (r_state == ST_DONE) && write_en;

    // Memory update: a config beat always wins over a user write or shift
    always_comb begin
        w_mem_next = r_mem;
        if (cen) begin
            for (int b = 0; b < BEATS; b++) begin
                if (w_beat_sel == CNT_W'(b)) begin
                    w_mem_next[b*CONFIG_WIDTH +: CONFIG_WIDTH] = config_in;
                end else begin
                    w_mem_next[b*CONFIG_WIDTH +: CONFIG_WIDTH] = r_mem[b*CONFIG_WIDTH +: CONFIG_WIDTH];
                end
            end
        end else if (w_user_wr && (mode == MODE_RAM)) begin
            w_mem_next[waddr] = data_in;
        end else if (w_user_wr && (mode == MODE_SRL)) begin
            w_mem_next = {r_mem[MEM_SIZE-2:0], data_in};
        end else begin
            w_mem_next = r_mem;
        end
    end

    assign w_lo_addr = {1'b0, addr[INPUTS-2:0]};
    assign w_hi_addr = {1'b1, addr[INPUTS-2:0]};

    // Output decode: reads are masked until the whole image is loaded
    always_comb begin
        w_config_done = (r_state == ST_DONE);
        if (!w_config_done) begin
            w_out = 2'b00;
        end else if (frac) begin
            w_out = {r_mem[w_hi_addr], r_mem[w_lo_addr]};
        end else begin
            w_out = {1'b0, r_mem[addr]};
        end
    end

    assign out         = w_out;
    assign config_done = w_config_done;
    assign shift_out   = r_mem[MEM_SIZE-1];

endmodule

// File: tb/tb_lut_m_frac.sv
// Directed bench for lut_m_frac: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_lut_m_frac;

    logic       clk;
    logic       rst;
    logic [3:0] addr;
    logic       frac;
    logic [1:0] mode;
    logic       cen;
    logic [3:0] config_in;
    logic       config_done;
    logic       data_in;
    logic       write_en;
    logic [3:0] waddr;
    logic [1:0] out;
    logic       shift_out;

    lut_m_frac #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .frac(frac), .mode(mode),
        .cen(cen), .config_in(config_in), .config_done(config_done),
        .data_in(data_in), .write_en(write_en), .waddr(waddr),
        .out(out), .shift_out(shift_out)
    );

    typedef struct {
        int         kind;   // 0: out, 1: config_done, 2: shift_out
        logic [1:0] exp;
        string      name;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [15:0] img;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            case (e.kind)
                0: begin
                    if (out === e.exp) n_pass++;
                    else $display("FAIL %s: out got %b expected %b", e.name, out, e.exp);
                end
                1: begin
                    if (config_done === e.exp[0]) n_pass++;
                    else $display("FAIL %s: config_done got %b expected %b", e.name, config_done, e.exp[0]);
                end
                default: begin
                    if (shift_out === e.exp[0]) n_pass++;
                    else $display("FAIL %s: shift_out got %b expected %b", e.name, shift_out, e.exp[0]);
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input int kind, input logic [1:0] exp, input string name);
        q.push_back('{kind, exp, name});
        @(negedge clk); #1;
    endtask

    task automatic beat(input logic [3:0] d);
        cen = 1'b1; config_in = d;
        @(posedge clk); #1;
        cen = 1'b0;
    endtask

    task automatic ram_wr(input logic [1:0] m, input logic [3:0] wa, input logic d,
                          input logic eb, input logic ea, input string name);
        @(posedge clk); #1;
        mode = m; waddr = wa; addr = wa; data_in = d; write_en = 1'b1;
        chk(0, {1'b0, eb}, {name, "_pre"});
        @(posedge clk); #1;
        write_en = 1'b0;
        chk(0, {1'b0, ea}, {name, "_post"});
    endtask

    initial begin
        rst = 1'b1; addr = 4'd0; frac = 1'b0; mode = 2'b00; cen = 1'b0;
        config_in = 4'd0; data_in = 1'b0; write_en = 1'b0; waddr = 4'd0;
        img = 16'h0F5A;
        @(posedge clk); @(posedge clk); #1;
        chk(0, 2'b00, "rst_out");
        chk(1, 2'b00, "rst_done");
        chk(2, 2'b00, "rst_shift");
        rst = 1'b0;

        // Load 0F5A; reads stay masked until the last beat
        addr = 4'd1;
        beat(4'hA); chk(1, 2'b00, "load_b0_done"); chk(0, 2'b00, "load_gated_out");
        beat(4'h5); chk(1, 2'b00, "load_b1_done");
        beat(4'hF); chk(1, 2'b00, "load_b2_done");
        beat(4'h0); chk(1, 2'b01, "load_b3_done");
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0];
            chk(0, {1'b0, img[a]}, $sformatf("sweep_a%0d", a));
        end

        // Fractured read
        frac = 1'b1;
        addr = 4'd3;  chk(0, 2'b11, "frac_a3");
        addr = 4'd11; chk(0, 2'b11, "frac_a11");
        addr = 4'd0;  chk(0, 2'b10, "frac_a0");
        addr = 4'd5;  chk(0, 2'b00, "frac_a5");
        frac = 1'b0;

        // RAM writes and ROM/11 write suppression
        ram_wr(2'b01, 4'd4, 1'b1, 1'b1, 1'b1, "ram_w4_1");
        ram_wr(2'b01, 4'd4, 1'b0, 1'b1, 1'b0, "ram_w4_0");
        ram_wr(2'b01, 4'd4, 1'b1, 1'b0, 1'b1, "ram_w4_1b");
        ram_wr(2'b01, 4'd7, 1'b1, 1'b0, 1'b1, "ram_w7_1");
        ram_wr(2'b00, 4'd4, 1'b0, 1'b1, 1'b1, "rom_w4");
        ram_wr(2'b11, 4'd7, 1'b0, 1'b1, 1'b1, "mode11_w7");
        chk(2, 2'b00, "ram_shift_out");

        // cen and write_en together: beat 0 taken, write to bit 15 dropped
        @(posedge clk); #1;
        mode = 2'b01; waddr = 4'd15; data_in = 1'b1; write_en = 1'b1;
        cen = 1'b1; config_in = 4'h3;
        @(posedge clk); #1;
        cen = 1'b0; write_en = 1'b0;
        chk(1, 2'b00, "conf_done_fall");
        chk(2, 2'b00, "conf_write_drop");
        beat(4'h5); beat(4'hF); beat(4'h0);
        chk(1, 2'b01, "conf_reload_done");
        addr = 4'd0; chk(0, 2'b01, "conf_b0_a0");
        addr = 4'd3; chk(0, 2'b00, "conf_b0_a3");

        // Reset in the middle of a load
        ram_wr(2'b01, 4'd15, 1'b1, 1'b0, 1'b1, "ram_w15");
        chk(2, 2'b01, "ram_w15_shift");
        mode = 2'b00;
        beat(4'hC);
        chk(2, 2'b01, "shift_ungated");
        chk(1, 2'b00, "mid_b0_done");
        beat(4'h9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(1, 2'b00, "midrst_done");
        chk(2, 2'b00, "midrst_mem_clr");
        beat(4'h1); beat(4'h2); beat(4'h4);
        chk(1, 2'b00, "midrst_b2_done");
        beat(4'h8);
        chk(1, 2'b01, "midrst_b3_done");
        addr = 4'd0;  chk(0, 2'b01, "midrst_a0");
        addr = 4'd1;  chk(0, 2'b00, "midrst_a1");
        addr = 4'd5;  chk(0, 2'b01, "midrst_a5");
        addr = 4'd10; chk(0, 2'b01, "midrst_a10");
        addr = 4'd14; chk(0, 2'b00, "midrst_a14");
        chk(2, 2'b01, "midrst_shift");

        // Shift register: single 1 walks to shift_out in 16 shifts
        beat(4'h0); beat(4'h0); beat(4'h0); beat(4'h0);
        chk(2, 2'b00, "srl_clear");
        mode = 2'b10;
        for (int k = 0; k < 16; k++) begin
            data_in = (k == 0); write_en = 1'b1;
            @(posedge clk); #1;
            write_en = 1'b0; addr = k[3:0];
            chk(0, 2'b01, $sformatf("srl_out_k%0d", k));
            chk(2, {1'b0, (k == 15)}, $sformatf("srl_so_k%0d", k));
        end
        mode = 2'b00; data_in = 1'b0; write_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0;
        chk(2, 2'b01, "rom_no_shift");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lut_m_frac.md
# lut_m_frac

Parametrised, fracturable memory LUT for the CLB. It extends the single-port memory LUT with a multi-beat block configuration loader, three run-time modes (ROM, single-bit RAM, shift register) and a fractured dual-output read. Configuration and user writes are clocked on one clock. It sits in the slice in place of a plain LUT and provides a cascade output for SRL chaining to the neighbouring LUT.

## Interface
- INPUTS, 4, address bits of the full LUT (>= 2)
- MEM_SIZE, 2**INPUTS, storage bits
- CONFIG_WIDTH, 4, config bits per load beat; MEM_SIZE is a multiple of CONFIG_WIDTH
- One clock; reset is synchronous and active-high.
- clk  in  1  single clock for config, write and shift
- rst  in  1  synchronous, active-high reset
- addr  in  INPUTS  read address
- frac  in  1  1 = fractured: two (INPUTS-1)-input LUTs
- mode  in  2  00 ROM, 01 RAM, 10 SRL, 11 treated as ROM
- cen  in  1  config beat valid
- config_in  in  CONFIG_WIDTH  config beat data
- config_done  out  1  memory fully loaded, LUT live
- data_in  in  1  write / shift-in bit
- write_en  in  1  RAM write or SRL shift strobe
- waddr  in  INPUTS  RAM write address
- out  out  2  LUT outputs
- shift_out  out  1  mem[MEM_SIZE-1], SRL cascade

## Operation
- Storage: mem[MEM_SIZE-1:0] flops. BEATS = MEM_SIZE/CONFIG_WIDTH. Beat counter width is max(1, clog2(BEATS)).
- Loader FSM states are IDLE, LOAD and DONE.
  - IDLE, cen=1: mem[0 +: CW] <= config_in, cnt <= 1, go to LOAD. If BEATS==1, go directly to DONE.
  - LOAD, cen=1: mem[cnt*CW +: CW] <= config_in, cnt++. On the beat where cnt==BEATS-1, go to DONE and clear cnt.
  - LOAD, cen=0: hold. Beats need not be contiguous.
  - DONE, cen=1: start a reload. Write beat 0, cnt <= 1, go to LOAD; config_done falls the next cycle.
- Reset, including mid-load: state IDLE, cnt 0, mem all 0, config_done 0.
- Read (combinational from mem, gated by config_done; outputs are 0 when not DONE):
  - frac=0: out[0] = mem[addr], out[1] = 0.
  - frac=1: out[0] = mem[{1'b0, addr[INPUTS-2:0]}], out[1] = mem[{1'b1, addr[INPUTS-2:0]}]. addr[INPUTS-1] is ignored.
- User writes act only in DONE with cen=0:
  - RAM (mode 01), write_en=1: mem[waddr] <= data_in.
  - SRL (mode 10), write_en=1: mem <= {mem[MEM_SIZE-2:0], data_in}.
  - ROM (00/11): write_en is ignored.
- shift_out = mem[MEM_SIZE-1]. It is not gated by config_done.
- Simultaneous cen and write_en: cen wins and the write/shift is dropped.
- mode and frac are quasi-static. A mode change takes effect on the next edge, and the memory contents are retained.

## Timing
- Reset values: out=2'b00, config_done=0, shift_out=0.
- Config latency: config_done rises on the edge that captures beat BEATS-1, so it is visible the cycle after the last cen.
- Read: zero-cycle combinational path from addr/frac/mode-independent memory to out.
- Write/shift: mem updates on the clk edge. Read-during-write returns the old value before the edge and the new value after it.
- SRL: one shift per write_en cycle. Bit data_in reaches shift_out after MEM_SIZE shifts.
- No back-pressure. The loader accepts a beat every cycle cen=1.

## Test plan
- Load and read: defaults, rst, then 4 beats 4'hA,4'h5,4'hF,4'h0 (mem=16'h0F5A).
  - config_done=0 through beat 3 and 1 the cycle after beat 4.
  - Sweeping addr 0..15 gives out[0] = bit addr of 16'h0F5A; out[1]=0.
- Fracture: with mem=16'h0F5A, frac=1, addr=3 → out=2'b{mem[11],mem[3]}=2'b11. addr=11 gives the same result.
- RAM write: mode=01, write_en=1, waddr=4, data_in=1.
  - Before the edge, out[0] at addr=4 reads 1 (old).
  - Repeat with data_in=0: it reads 0 after the edge.
  - In mode=00 the same write leaves mem unchanged.
- SRL: mode=10, mem=0, shift in 1 followed by 15 zeros.
  - shift_out=0 for 15 edges and 1 after the 16th.
  - out[0] at addr=k shows the 1 after k+1 shifts.
- Conflicts: in DONE, assert cen and write_en together.
  - Beat 0 is loaded, the write is dropped, and config_done=0 the next cycle.
- Reset mid-load: rst after 2 beats → mem=0, config_done=0. The next cen is treated as beat 0.
